vscale_htif_tohost_poller: RTL and testbench
============================================

Name: vscale_htif_tohost_poller

Overview:
- Host-side HTIF PCR master that sits directly upstream of the benchmark top and drives its htif_pcr_req_* / htif_pcr_resp_* ports.
- Periodically reads the tohost CSR through the PCR interface and detects program completion.
- On completion, clears tohost and reports pass or fail plus the exit code; flags a timeout if completion never arrives.
- Used by simulation and benchmark harnesses in place of a behavioural host model.

Parameters:
- CSR_ADDR_WIDTH, 12, PCR address width; matches `CSR_ADDR_WIDTH.
- PCR_WIDTH, 64, PCR data width; matches `HTIF_PCR_WIDTH.
- TOHOST_ADDR, 12'h780, CSR address polled and cleared.
- POLL_INTERVAL, 16, idle cycles between successive reads; must be ≥1.
- TIMEOUT_CYCLES, 32'd1000000, cycle budget before timeout; 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- htif_pcr_req_valid  output  1  request valid
- htif_pcr_req_ready  input  1  DUT accepts the request
- htif_pcr_req_rw  output  1  1 = write, 0 = read
- htif_pcr_req_addr  output  CSR_ADDR_WIDTH  CSR address
- htif_pcr_req_data  output  PCR_WIDTH  write data
- htif_pcr_resp_valid  input  1  response valid
- htif_pcr_resp_ready  output  1  poller accepts the response
- htif_pcr_resp_data  input  PCR_WIDTH  response data
- done  output  1  sticky; completion observed and tohost cleared
- pass  output  1  sticky; valid when done; 1 iff tohost == 1
- exit_code  output  PCR_WIDTH  tohost >> 1 (zero-extended), captured at completion
- timed_out  output  1  sticky; budget exhausted before completion
- poll_count  output  32  number of completed tohost reads; saturates at 32'hFFFFFFFF

Behaviour:
- Clocking and reset: single clock domain, clk, with a synchronous active-high reset. Reset forces state WAIT, loads the interval counter with POLL_INTERVAL-1, and clears the cycle counter.
- Reset values: req_valid=0, resp_ready=0, req_rw=0, req_addr=0, req_data=0, done=0, pass=0, exit_code=0, timed_out=0, poll_count=0.
- Reset mid-transaction abandons the transaction immediately; a later DUT response is not accepted because resp_ready=0.
- WAIT: the interval counter decrements each cycle. At 0, go to RD_REQ.
- Timeout check in WAIT: if TIMEOUT_CYCLES != 0 and the cycle counter ≥ TIMEOUT_CYCLES, go to TIMEOUT instead of RD_REQ. The check is evaluated only in WAIT, so in-flight handshakes always complete.
- RD_REQ: req_valid=1, rw=0, addr=TOHOST_ADDR, data=0.
  - Hold all request fields stable until req_valid && req_ready in the same cycle, then go to RD_RESP in the next cycle.
- RD_RESP: resp_ready=1. On resp_valid, increment poll_count (saturating) and branch on the data:
  - data == 0: reload the interval counter, go to WAIT.
  - data != 0: capture pass=(data==1) and exit_code=data>>1, go to CLR_REQ.
- CLR_REQ: req_valid=1, rw=1, addr=TOHOST_ADDR, data=0. Handshake as in RD_REQ, then go to CLR_RESP.
- CLR_RESP: resp_ready=1. Every PCR write returns a response; its data is discarded. On resp_valid, set done=1 and go to DONE.
- DONE and TIMEOUT: terminal, left only by reset. req_valid=0, resp_ready=0.
  - TIMEOUT sets timed_out=1; done and pass stay 0.
- Cycle counter: 32 bits, increments every cycle outside DONE and TIMEOUT, saturates at all-ones.
- resp_ready is 1 only in RD_RESP and CLR_RESP. A resp_valid in any other state is ignored and not consumed.
- Only one transaction is ever outstanding; no new request is issued before the previous response is accepted.
- Simultaneous events:
  - A request handshake and a response in the same cycle cannot overlap, because the states are disjoint.
  - resp_valid arriving in the same cycle as req_ready is not accepted; it is accepted next cycle once in a RESP state, provided the DUT holds it.
- Latency: first read request is asserted POLL_INTERVAL cycles after reset deasserts. Back-to-back polls are spaced by POLL_INTERVAL + handshake cycles.
- Request fields are registered outputs, with no combinational path from any input to any output.

Test Plan:
- Basic pass, POLL_INTERVAL=4: DUT stub returns tohost=0 twice, then 1.
  - Expect 3 reads to addr 0x780, then a write of 0 to 0x780.
  - Expect done=1, pass=1, exit_code=0, poll_count=3.
- Fail code: stub returns tohost=0x7 on the first read.
  - Expect done=1, pass=0, exit_code=3, poll_count=1, and a clear write issued.
- Backpressure: req_ready held low for 10 cycles, then resp_valid delayed 5 cycles.
  - Expect req_valid, req_rw, req_addr and req_data stable throughout.
  - Expect exactly one request accepted and one response consumed per transaction.
- Timeout: TIMEOUT_CYCLES=100, stub always returns 0.
  - Expect timed_out=1 and done=0.
  - Expect no req_valid after entering TIMEOUT, and the final outstanding read completes first.
- Reset mid-transaction: assert reset while in RD_RESP, with the stub later driving resp_valid.
  - Expect all outputs at their reset values the cycle after reset, resp_ready=0, and the stale response not consumed.
  - Expect the first new request POLL_INTERVAL cycles after reset deasserts.
- Spurious response: resp_valid pulsed while in WAIT.
  - Expect resp_ready=0, poll_count unchanged, and no state change.

Source files
------------

// File: rtl/vscale_htif_tohost_poller.sv
// rtl/vscale_htif_tohost_poller.sv - HTIF PCR master that polls tohost, clears it and reports completion
module vscale_htif_tohost_poller #(
   parameter int                        CSR_ADDR_WIDTH = 12,
   parameter int                        PCR_WIDTH      = 64,
   parameter logic [CSR_ADDR_WIDTH-1:0] TOHOST_ADDR    = 12'h780,
   parameter int                        POLL_INTERVAL  = 16,
   parameter logic [31:0]               TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      htif_pcr_req_valid,
   input  logic                      htif_pcr_req_ready,
   output logic                      htif_pcr_req_rw,
   output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
   output logic [PCR_WIDTH-1:0]      htif_pcr_req_data,
   input  logic                      htif_pcr_resp_valid,
   output logic                      htif_pcr_resp_ready,
   input  logic [PCR_WIDTH-1:0]      htif_pcr_resp_data,
   output logic                      done,
   output logic                      pass,
   output logic [PCR_WIDTH-1:0]      exit_code,
   output logic                      timed_out,
   output logic [31:0]               poll_count
);

   typedef enum logic [2:0] {
      S_WAIT, S_RD_REQ, S_RD_RESP, S_CLR_REQ, S_CLR_RESP, S_DONE, S_TIMEOUT
   } state_t;

   localparam logic [31:0] INTERVAL_RELOAD = 32'(POLL_INTERVAL - 1);
   localparam logic        TIMEOUT_EN      = (TIMEOUT_CYCLES != 32'd0);

   state_t      state;
   logic [31:0] interval_cnt;
   logic [31:0] cycle_cnt;
   logic        req_fire;
   logic        resp_fire;

   assign req_fire  = htif_pcr_req_valid && htif_pcr_req_ready;
   assign resp_fire = htif_pcr_resp_valid && htif_pcr_resp_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= S_WAIT;
         interval_cnt        <= INTERVAL_RELOAD;
         cycle_cnt           <= '0;
         htif_pcr_req_valid  <= 1'b0;
         htif_pcr_req_rw     <= 1'b0;
         htif_pcr_req_addr   <= '0;
         htif_pcr_req_data   <= '0;
         htif_pcr_resp_ready <= 1'b0;
         done                <= 1'b0;
         pass                <= 1'b0;
         exit_code           <= '0;
         timed_out           <= 1'b0;
         poll_count          <= '0;
      end else begin
         if (state != S_DONE && state != S_TIMEOUT && cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 32'd1;

         case (state)
            // Timeout is only taken from WAIT so a started handshake always finishes.
            S_WAIT: begin
               if (TIMEOUT_EN && cycle_cnt >= TIMEOUT_CYCLES) begin
                  state     <= S_TIMEOUT;
                  timed_out <= 1'b1;
               end else if (interval_cnt == 32'd0) begin
                  state              <= S_RD_REQ;
                  htif_pcr_req_valid <= 1'b1;
                  htif_pcr_req_rw    <= 1'b0;
                  htif_pcr_req_addr  <= TOHOST_ADDR;
                  htif_pcr_req_data  <= '0;
               end else begin
                  interval_cnt <= interval_cnt - 32'd1;
               end
            end
            S_RD_REQ: begin
               if (req_fire) begin
                  state               <= S_RD_RESP;
                  htif_pcr_req_valid  <= 1'b0;
                  htif_pcr_resp_ready <= 1'b1;
               end
            end
            S_RD_RESP: begin
               if (resp_fire) begin
                  htif_pcr_resp_ready <= 1'b0;
                  if (poll_count != '1)
                     poll_count <= poll_count + 32'd1;
                  if (htif_pcr_resp_data == '0) begin
                     state        <= S_WAIT;
                     interval_cnt <= INTERVAL_RELOAD;
                  end else begin
                     state              <= S_CLR_REQ;
                     pass               <= (htif_pcr_resp_data == PCR_WIDTH'(1));
                     exit_code          <= htif_pcr_resp_data >> 1;
                     htif_pcr_req_valid <= 1'b1;
                     htif_pcr_req_rw    <= 1'b1;
                     htif_pcr_req_addr  <= TOHOST_ADDR;
                     htif_pcr_req_data  <= '0;
                  end
               end
            end
            S_CLR_REQ: begin
               if (req_fire) begin
                  state               <= S_CLR_RESP;
                  htif_pcr_req_valid  <= 1'b0;
                  htif_pcr_resp_ready <= 1'b1;
               end
            end
            S_CLR_RESP: begin
               if (resp_fire) begin
                  state               <= S_DONE;
                  htif_pcr_resp_ready <= 1'b0;
                  done                <= 1'b1;
               end
            end
            S_DONE, S_TIMEOUT: begin
               htif_pcr_req_valid  <= 1'b0;
               htif_pcr_resp_ready <= 1'b0;
            end
            default: begin
               state               <= S_WAIT;
               interval_cnt        <= INTERVAL_RELOAD;
               htif_pcr_req_valid  <= 1'b0;
               htif_pcr_resp_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vscale_htif_tohost_poller.sv
// tb/tb_vscale_htif_tohost_poller.sv - directed self-checking bench for the tohost poller
module tb_vscale_htif_tohost_poller;

   localparam int PI = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        req_rw;
   logic [11:0] req_addr;
   logic [63:0] req_data;
   logic        resp_valid = 1'b0;
   logic        resp_ready;
   logic [63:0] resp_data = '0;
   logic        done;
   logic        pass;
   logic [63:0] exit_code;
   logic        timed_out;
   logic [31:0] poll_count;

   int checks = 0;
   int errors = 0;

   vscale_htif_tohost_poller #(
      .CSR_ADDR_WIDTH(12),
      .PCR_WIDTH(64),
      .TOHOST_ADDR(12'h780),
      .POLL_INTERVAL(PI),
      .TIMEOUT_CYCLES(32'd100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .htif_pcr_req_valid(req_valid),
      .htif_pcr_req_ready(req_ready),
      .htif_pcr_req_rw(req_rw),
      .htif_pcr_req_addr(req_addr),
      .htif_pcr_req_data(req_data),
      .htif_pcr_resp_valid(resp_valid),
      .htif_pcr_resp_ready(resp_ready),
      .htif_pcr_resp_data(resp_data),
      .done(done),
      .pass(pass),
      .exit_code(exit_code),
      .timed_out(timed_out),
      .poll_count(poll_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_req_valid", req_valid, 0);
      check("rst_resp_ready", resp_ready, 0);
      check("rst_req_rw", req_rw, 0);
      check("rst_req_addr", req_addr, 0);
      check("rst_req_data", req_data, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_exit_code", exit_code, 0);
      check("rst_timed_out", timed_out, 0);
      check("rst_poll_count", poll_count, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_ready = 1'b0;
      resp_valid = 1'b0;
      resp_data = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!req_valid && !timed_out && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("wait_req_bound", 0, 1);
   endtask

   task automatic serve(input int rdy_dly, input int rsp_dly, input logic exp_rw,
                        input logic [63:0] rdata);
      check("req_valid", req_valid, 1);
      check("req_rw", req_rw, exp_rw);
      check("req_addr", req_addr, 64'h780);
      check("req_data", req_data, 0);
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         check("hold_valid", req_valid, 1);
         check("hold_rw", req_rw, exp_rw);
         check("hold_addr", req_addr, 64'h780);
         check("hold_data", req_data, 0);
         check("hold_resp_ready", resp_ready, 0);
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check("req_once", req_valid, 0);
      check("resp_ready_up", resp_ready, 1);
      for (int i = 0; i < rsp_dly; i++) begin
         @(negedge clk);
         check("resp_wait_ready", resp_ready, 1);
         check("no_new_req", req_valid, 0);
      end
      resp_valid = 1'b1;
      resp_data = rdata;
      @(negedge clk);
      resp_valid = 1'b0;
      resp_data = '0;
      check("resp_once", resp_ready, 0);
   endtask

   initial begin
      int n;
      int polls;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs();

      // Basic pass: 0, 0, 1 then clear write
      do_reset();
      wait_req(n);
      check("first_req_latency", n, PI);
      serve(0, 0, 1'b0, 64'd0);
      wait_req(n);
      check("poll_spacing", n, PI);
      serve(0, 0, 1'b0, 64'd0);
      wait_req(n);
      serve(0, 0, 1'b0, 64'd1);
      check("pass_not_done_yet", done, 0);
      serve(0, 0, 1'b1, 64'hdead);
      check("pass_done", done, 1);
      check("pass_pass", pass, 1);
      check("pass_exit", exit_code, 0);
      check("pass_polls", poll_count, 3);
      repeat (5) @(negedge clk);
      check("done_quiet_req", req_valid, 0);
      check("done_quiet_resp", resp_ready, 0);

      // Fail code 7 -> exit 3
      do_reset();
      wait_req(n);
      serve(0, 0, 1'b0, 64'd7);
      serve(0, 0, 1'b1, 64'd0);
      check("fail_done", done, 1);
      check("fail_pass", pass, 0);
      check("fail_exit", exit_code, 3);
      check("fail_polls", poll_count, 1);

      // Backpressure on both request and response
      do_reset();
      wait_req(n);
      serve(10, 5, 1'b0, 64'd5);
      check("bp_polls", poll_count, 1);
      serve(10, 5, 1'b1, 64'd0);
      check("bp_done", done, 1);
      check("bp_exit", exit_code, 2);
      check("bp_polls_final", poll_count, 1);

      // Spurious response in WAIT
      do_reset();
      @(negedge clk);
      resp_valid = 1'b1;
      resp_data = 64'd1;
      check("spur_resp_ready", resp_ready, 0);
      @(negedge clk);
      resp_valid = 1'b0;
      resp_data = '0;
      check("spur_polls", poll_count, 0);
      check("spur_req_valid", req_valid, 0);
      check("spur_done", done, 0);
      wait_req(n);
      check("spur_latency", n + 2, PI);
      serve(0, 0, 1'b0, 64'd0);
      check("spur_polls_after", poll_count, 1);

      // Reset while in RD_RESP, stale response held afterwards
      do_reset();
      wait_req(n);
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check("mid_in_resp", resp_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;
      resp_valid = 1'b1;
      resp_data = 64'd1;
      @(negedge clk);
      check("mid_stale_ready", resp_ready, 0);
      check("mid_stale_polls", poll_count, 0);
      @(negedge clk);
      resp_valid = 1'b0;
      resp_data = '0;
      check("mid_stale_polls2", poll_count, 0);
      wait_req(n);
      check("mid_restart_latency", n + 2, PI);
      serve(0, 0, 1'b0, 64'd1);
      serve(0, 0, 1'b1, 64'd0);
      check("mid_done", done, 1);
      check("mid_polls", poll_count, 1);

      // Timeout at 100 cycles with tohost always 0
      do_reset();
      polls = 0;
      while (polls < 40) begin
         wait_req(n);
         if (timed_out || n >= 300) break;
         serve(0, 0, 1'b0, 64'd0);
         polls++;
      end
      check("to_timed_out", timed_out, 1);
      check("to_done", done, 0);
      check("to_pass", pass, 0);
      check("to_polls_served", polls, 17);
      check("to_poll_count", poll_count, 17);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_valid || resp_ready) begin
            check("to_quiet", {req_valid, resp_ready}, 0);
            break;
         end
      end
      check("to_sticky", timed_out, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1);
   end

endmodule
